// File: rtl/spare_logic_monitor_if.sv
// Read / control bundle between a host and spare_logic_monitor.
//
// Handshake: the host raises rd_req_i with rd_addr_i valid and keeps rd_req_i
// high until it sees rd_ack_o. The monitor takes rd_addr_i when it accepts
// the request. rd_ack_o is high for exactly one cycle, and rd_data_o is valid
// only in that cycle (zero otherwise). The host must drop rd_req_i before
// the next request is accepted, so one request gets exactly one ack.
interface spare_logic_monitor_if;
    logic        clr_i;
    logic        rd_req_i;
    logic [1:0]  rd_addr_i;
    logic        rd_ack_o;
    logic [31:0] rd_data_o;
    logic        irq_o;
    logic [0:0]  dbg_mon_state_o;
    logic [1:0]  dbg_rd_state_o;

    modport slave (
        input  clr_i, rd_req_i, rd_addr_i,
        output rd_ack_o, rd_data_o, irq_o, dbg_mon_state_o, dbg_rd_state_o
    );

    modport master (
        output clr_i, rd_req_i, rd_addr_i,
        input  rd_ack_o, rd_data_o, irq_o, dbg_mon_state_o, dbg_rd_state_o
    );
endinterface

// File: rtl/spare_logic_monitor.sv
// Spare-cell monitor: synchronises the packed spare-cell outputs, waits for
// them to settle after reset, then records every bit that differs from the
// no-ECO value in sticky flags and counts the mismatching cycles. State can
// be read as four 32-bit words over a req/ack port.
module spare_logic_monitor #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter logic [41:0] EXPECTED      = 42'h0
) (
`ifdef USE_POWER_PINS
    inout  wire         vccd,
    inout  wire         vssd,
`endif
    input  logic        wb_clk_i,
    input  logic        wb_rstn_i,
    input  logic [26:0] spare_xz,
    input  logic [3:0]  spare_xi,
    input  logic        spare_xib,
    input  logic [1:0]  spare_xna,
    input  logic [1:0]  spare_xno,
    input  logic [1:0]  spare_xmx,
    input  logic [1:0]  spare_xfq,
    input  logic [1:0]  spare_xfqn,
    spare_logic_monitor_if.slave bus
);

    localparam logic [0:0] MON_SETTLE = 1'b0;
    localparam logic [0:0] MON_ARMED  = 1'b1;

    localparam logic [1:0] RD_IDLE = 2'd0;
    localparam logic [1:0] RD_ACK  = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    logic [41:0] spare_vec;
    logic [41:0] sync1_q, sync_q;
    logic [0:0]  mon_state_q, mon_state_d;
    logic [7:0]  settle_cnt_q, settle_cnt_d;
    logic [1:0]  arm_pipe_q;
    logic        armed;
    logic        check_en;
    logic [41:0] mismatch;
    logic        any_mismatch;
    logic [41:0] sticky_q, sticky_d;
    logic [7:0]  mis_cnt_q, mis_cnt_d;
    logic        irq_q;
    logic [1:0]  rd_state_q, rd_state_d;
    logic [1:0]  rd_addr_q, rd_addr_d;
    logic        rd_ack_q, rd_ack_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [31:0] read_word;

    assign spare_vec = {spare_xfqn, spare_xfq, spare_xmx, spare_xno,
                        spare_xna, spare_xib, spare_xi, spare_xz};

    // Two-flop synchroniser for the asynchronous spare-cell outputs.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            sync1_q <= '0;
            sync_q  <= '0;
        end else begin
            sync1_q <= spare_vec;
            sync_q  <= sync1_q;
        end
    end

    // Settle counter: SETTLE counts up and moves to ARMED on its last count.
    always_comb begin
        mon_state_d  = mon_state_q;
        settle_cnt_d = settle_cnt_q;
        if (mon_state_q == MON_SETTLE) begin
            settle_cnt_d = settle_cnt_q + 8'd1;
            if (settle_cnt_q == SETTLE_LAST) begin
                mon_state_d = MON_ARMED;
            end
        end
    end

    assign armed = (mon_state_q == MON_ARMED);

    // Monitor FSM registers. arm_pipe delays checking by the synchroniser
    // depth so that only samples taken after arming are compared.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            mon_state_q  <= MON_SETTLE;
            settle_cnt_q <= '0;
            arm_pipe_q   <= '0;
        end else begin
            mon_state_q  <= mon_state_d;
            settle_cnt_q <= settle_cnt_d;
            arm_pipe_q   <= {arm_pipe_q[0], armed};
        end
    end

    assign check_en     = armed & arm_pipe_q[1];
    assign mismatch     = check_en ? (sync_q ^ EXPECTED) : '0;
    assign any_mismatch = |mismatch;

    // Sticky flags and saturating counter; a new mismatch wins over clear.
    always_comb begin
        sticky_d  = bus.clr_i ? mismatch : (sticky_q | mismatch);
        mis_cnt_d = mis_cnt_q;
        if (bus.clr_i) begin
            mis_cnt_d = any_mismatch ? 8'd1 : 8'd0;
        end else if (any_mismatch && (mis_cnt_q != 8'hFF)) begin
            mis_cnt_d = mis_cnt_q + 8'd1;
        end
    end

    // Sticky, counter and interrupt registers.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            sticky_q  <= '0;
            mis_cnt_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            sticky_q  <= sticky_d;
            mis_cnt_q <= mis_cnt_d;
            irq_q     <= |sticky_q;
        end
    end

    // Read word select from the address latched at request acceptance.
    always_comb begin
        read_word = '0;
        case (rd_addr_q)
            2'd0: read_word = sync_q[31:0];
            2'd1: read_word = {armed, 21'b0, sync_q[41:32]};
            2'd2: read_word = sticky_q[31:0];
            2'd3: read_word = {mis_cnt_q, 14'b0, sticky_q[41:32]};
            default: read_word = '0;
        endcase
    end

    // Read FSM: accept, acknowledge once, then wait for the request to drop.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_addr_d  = rd_addr_q;
        rd_ack_d   = 1'b0;
        rd_data_d  = '0;
        case (rd_state_q)
            RD_IDLE: begin
                if (bus.rd_req_i) begin
                    rd_addr_d  = bus.rd_addr_i;
                    rd_state_d = RD_ACK;
                end
            end
            RD_ACK: begin
                rd_ack_d   = 1'b1;
                rd_data_d  = read_word;
                rd_state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (!bus.rd_req_i) begin
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Read FSM registers; ack and data are registered so data is zero off-ack.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            rd_state_q <= RD_IDLE;
            rd_addr_q  <= '0;
            rd_ack_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_addr_q  <= rd_addr_d;
            rd_ack_q   <= rd_ack_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.rd_ack_o        = rd_ack_q;
    assign bus.rd_data_o       = rd_data_q;
    assign bus.irq_o           = irq_q;
    assign bus.dbg_mon_state_o = mon_state_q;
    assign bus.dbg_rd_state_o  = rd_state_q;

endmodule

// File: tb/tb_spare_logic_monitor.sv
// Bench for spare_logic_monitor: directed scenarios plus randomized traffic,
// checked against a cycle-level reference model of the monitor rules.
module tb_spare_logic_monitor;

  localparam logic [41:0] EXP = {2'b10, 40'hA5_C30F_1234};
  localparam int SC = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [41:0] tb_v;
  logic [26:0] spare_xz;
  logic [3:0]  spare_xi;
  logic        spare_xib;
  logic [1:0]  spare_xna, spare_xno, spare_xmx, spare_xfq, spare_xfqn;

  assign spare_xz   = tb_v[26:0];
  assign spare_xi   = tb_v[30:27];
  assign spare_xib  = tb_v[31];
  assign spare_xna  = tb_v[33:32];
  assign spare_xno  = tb_v[35:34];
  assign spare_xmx  = tb_v[37:36];
  assign spare_xfq  = tb_v[39:38];
  assign spare_xfqn = tb_v[41:40];

  spare_logic_monitor_if bus ();

  spare_logic_monitor #(
    .SETTLE_CYCLES(SC),
    .EXPECTED(EXP)
  ) dut (
    .wb_clk_i(clk),
    .wb_rstn_i(rstn),
    .spare_xz(spare_xz),
    .spare_xi(spare_xi),
    .spare_xib(spare_xib),
    .spare_xna(spare_xna),
    .spare_xno(spare_xno),
    .spare_xmx(spare_xmx),
    .spare_xfq(spare_xfq),
    .spare_xfqn(spare_xfqn),
    .bus(bus)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  // hist holds the input vector seen at the last two edges; what the
  // synchronised view shows is the older of those two samples.
  logic [41:0] hist[$];
  int          m_cyc = 0;       // edges since reset release
  logic [41:0] m_sticky = '0;
  int          m_cnt = 0;
  logic        m_irq = 1'b0;

  function automatic logic [41:0] m_sync();
    return (hist.size() == 2) ? hist[0] : 42'd0;
  endfunction

  function automatic logic m_armed();
    return (m_cyc >= SC);
  endfunction

  function automatic logic [31:0] model_word(input logic [1:0] a);
    logic [41:0] s;
    logic [7:0]  c;
    s = m_sync();
    c = 8'(m_cnt);
    case (a)
      2'd0:    return s[31:0];
      2'd1:    return {m_armed(), 21'b0, s[41:32]};
      2'd2:    return m_sticky[31:0];
      default: return {c, 14'b0, m_sticky[41:32]};
    endcase
  endfunction

  always @(posedge clk) begin : ref_model
    logic [41:0] mis;
    if (!rstn) begin
      hist.delete();
      m_cyc    = 0;
      m_sticky = '0;
      m_cnt    = 0;
      m_irq    = 1'b0;
    end else begin
      // Comparison starts once the synchronised sample was taken while armed.
      mis   = (m_cyc + 1 >= SC + 3) ? (m_sync() ^ EXP) : 42'd0;
      m_irq = |m_sticky;
      if (bus.clr_i) begin
        m_sticky = mis;
        m_cnt    = (mis != 42'd0) ? 1 : 0;
      end else begin
        m_sticky = m_sticky | mis;
        if (mis != 42'd0 && m_cnt < 255) m_cnt = m_cnt + 1;
      end
      hist.push_back(tb_v);
      if (hist.size() > 2) void'(hist.pop_front());
      m_cyc = m_cyc + 1;
    end
  end

  // Every cycle: interrupt follows the model, data is zero off-ack.
  logic mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      check("irq", 64'(bus.irq_o), 64'(m_irq));
      if (!bus.rd_ack_o) check("idle_data", 64'(bus.rd_data_o), 64'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // One complete read; called at a negedge. Optionally pulses clr_i in the
  // cycle the data is captured so the pre-clear value must be returned.
  task automatic do_read(input logic [1:0] addr, input bit clr_pulse,
                         input string tag, output logic [31:0] data);
    logic [31:0] exp_w;
    bus.rd_req_i  = 1'b1;
    bus.rd_addr_i = addr;
    tick(1);
    check({tag, "_ack_lat1"}, 64'(bus.rd_ack_o), 64'd0);
    exp_w = model_word(addr);
    if (clr_pulse) bus.clr_i = 1'b1;
    tick(1);
    bus.clr_i = 1'b0;
    check({tag, "_ack"}, 64'(bus.rd_ack_o), 64'd1);
    check({tag, "_data"}, 64'(bus.rd_data_o), 64'(exp_w));
    data = bus.rd_data_o;
    bus.rd_req_i = 1'b0;
    tick(1);
    check({tag, "_ack_drop"}, 64'(bus.rd_ack_o), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rd;
  logic [41:0] one42;
  int n_ack, ack_at;

  initial begin
    one42         = 42'd1;
    tb_v          = EXP;
    rstn          = 1'b0;
    bus.clr_i     = 1'b0;
    bus.rd_req_i  = 1'b0;
    bus.rd_addr_i = 2'd0;
    @(negedge clk);
    mon_en = 1'b1;
    check("rst_ack", 64'(bus.rd_ack_o), 64'd0);
    check("rst_data", 64'(bus.rd_data_o), 64'd0);
    check("rst_mon_state", 64'(bus.dbg_mon_state_o), 64'd0);
    check("rst_rd_state", 64'(bus.dbg_rd_state_o), 64'd0);
    tick(2);
    rstn = 1'b1;

    // Mismatch on spare_xz[5] only during settle.
    tb_v = EXP ^ (one42 << 5);
    tick(8);
    tb_v = EXP;
    tick(100);
    do_read(2'd2, 1'b0, "settle_w2", rd);
    check("settle_w2_zero", 64'(rd), 64'd0);
    do_read(2'd3, 1'b0, "quiet_w3", rd);
    check("quiet_w3_zero", 64'(rd), 64'd0);
    do_read(2'd1, 1'b0, "quiet_w1", rd);
    check("quiet_w1_armed", 64'(rd[31]), 64'd1);
    do_read(2'd0, 1'b0, "quiet_w0", rd);
    check("armed_state", 64'(bus.dbg_mon_state_o), 64'(m_armed()));

    // V[27] (spare_xi[0]) wrong for three cycles.
    tb_v = EXP ^ (one42 << 27);
    tick(3);
    tb_v = EXP;
    tick(5);
    do_read(2'd3, 1'b0, "xi0_w3", rd);
    check("xi0_w3_const", 64'(rd), 64'h0300_0000);
    do_read(2'd2, 1'b0, "xi0_w2", rd);
    check("xi0_w2_const", 64'(rd), 64'h0800_0000);

    // Clear coinciding with a new mismatch on V[3].
    tb_v = EXP ^ (one42 << 3);
    tick(1);
    tb_v = EXP;
    tick(1);
    bus.clr_i = 1'b1;
    tick(1);
    bus.clr_i = 1'b0;
    tick(2);
    do_read(2'd2, 1'b0, "clrset_w2", rd);
    check("clrset_w2_const", 64'(rd), 64'h8);
    do_read(2'd3, 1'b0, "clrset_w3", rd);
    check("clrset_w3_const", 64'(rd), 64'h0100_0000);

    // Read with clear in the capture cycle returns pre-clear state.
    do_read(2'd2, 1'b1, "preclr_w2", rd);
    check("preclr_w2_const", 64'(rd), 64'h8);
    do_read(2'd2, 1'b0, "postclr_w2", rd);
    check("postclr_w2_const", 64'(rd), 64'h0);

    // Long mismatch saturates the counter.
    tb_v = EXP ^ 42'h300_0000_0003;
    tick(300);
    tb_v = EXP;
    tick(3);
    do_read(2'd3, 1'b0, "sat_w3", rd);
    check("sat_cnt", 64'(rd[31:24]), 64'd255);
    do_read(2'd1, 1'b0, "sat_w1", rd);
    bus.clr_i = 1'b1;
    tick(1);
    bus.clr_i = 1'b0;
    tick(2);

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      int idle;
      idle = $urandom_range(1, 6);
      for (int c = 0; c < idle; c++) begin
        if ($urandom_range(0, 3) == 0)
          tb_v = EXP ^ (one42 << $urandom_range(0, 41));
        else
          tb_v = EXP;
        bus.clr_i = ($urandom_range(0, 9) == 0);
        tick(1);
      end
      bus.clr_i = 1'b0;
      do_read(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rnd", rd);
    end
    tb_v = EXP;
    tick(3);

    // Request held ten cycles: one ack, two cycles after the request.
    n_ack  = 0;
    ack_at = 0;
    bus.rd_req_i  = 1'b1;
    bus.rd_addr_i = 2'd3;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (bus.rd_ack_o) begin
        n_ack++;
        ack_at = i;
      end
    end
    bus.rd_req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (bus.rd_ack_o) n_ack++;
    end
    check("hold_ack_count", 64'(n_ack), 64'd1);
    check("hold_ack_cycle", 64'(ack_at), 64'd2);

    // Reset one cycle into a request: no ack, before or after release.
    n_ack = 0;
    bus.rd_req_i = 1'b1;
    bus.rd_addr_i = 2'd0;
    tick(1);
    rstn = 1'b0;
    bus.rd_req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (bus.rd_ack_o) n_ack++;
    end
    check("rst_mid_state", 64'(bus.dbg_rd_state_o), 64'd0);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (bus.rd_ack_o) n_ack++;
    end
    check("rst_mid_no_ack", 64'(n_ack), 64'd0);
    do_read(2'd1, 1'b0, "resettle_w1", rd);
    check("resettle_unarmed", 64'(rd[31]), 64'd0);
    do_read(2'd3, 1'b0, "resettle_w3", rd);
    check("resettle_w3_zero", 64'(rd), 64'd0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spare_logic_monitor.md
SPARE_LOGIC_MONITOR -- requirements
Module: spare_logic_monitor

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 16, giving the cycles after reset before mismatch checking arms (range 1-255).
REQ-002 The block SHALL have parameter EXPECTED, 42 bits, default 42'h0_0000_0000_0000, giving the no-ECO value of the packed spare vector.
REQ-003 The block SHALL have ports vccd and vssd, inout, 1 bit each, present only when USE_POWER_PINS is defined.
REQ-004 The block SHALL have port wb_clk_i, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 The block SHALL have port wb_rstn_i, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have ports spare_xz, spare_xi, spare_xib, spare_xna, spare_xno, spare_xmx, spare_xfq and spare_xfqn, all inputs, widths 27, 4, 1, 2, 2, 2, 2 and 2: the spare-cell outputs, asynchronous to wb_clk_i.
REQ-007 The block SHALL have port clr_i, input, 1 bit: a single-cycle pulse that clears the sticky flags and the counter.
REQ-008 The block SHALL have port rd_req_i, input, 1 bit: read request, held high until ack.
REQ-009 The block SHALL have port rd_addr_i, input, 2 bits: read word select, sampled when the request is accepted.
REQ-010 The block SHALL have port rd_ack_o, output, 1 bit: a one-cycle read acknowledge.
REQ-011 The block SHALL have port rd_data_o, output, 32 bits: read data, valid only while rd_ack_o is high.
REQ-012 The block SHALL have port irq_o, output, 1 bit: high while any sticky bit is set.

Function
REQ-013 The packed vector V[41:0] SHALL be {spare_xfqn, spare_xfq, spare_xmx, spare_xno, spare_xna, spare_xib, spare_xi, spare_xz}, with spare_xz at V[26:0].
REQ-014 V SHALL pass through a 2-flop synchronizer giving S[41:0]; latency from V change to S is 2 cycles.
REQ-015 The monitor FSM SHALL have states SETTLE and ARMED; reset enters SETTLE with settle counter = 0.
REQ-016 In SETTLE the counter SHALL increment each cycle, moving to ARMED on the cycle the counter reaches SETTLE_CYCLES-1; ARMED SHALL be held until reset.
REQ-017 In ARMED, each cycle it SHALL compute M = S ^ EXPECTED, set sticky[i] for every set M[i], and increment the 8-bit mismatch counter when M != 0.
REQ-018 No sticky or counter update SHALL occur in SETTLE.
REQ-019 The mismatch counter SHALL saturate at 255 with no wrap.
REQ-020 clr_i SHALL zero sticky and the counter in the next cycle; when clr_i and a mismatch bit coincide, that bit SHALL be set (set wins) and the counter SHALL load 1.
REQ-021 irq_o SHALL be registered and equal the OR of sticky with 1-cycle lag.
REQ-022 The read FSM SHALL have states RIDLE, RACK and RWAIT.
REQ-023 In RIDLE, rd_req_i=1 SHALL latch rd_addr_i and move the FSM to RACK.
REQ-024 In RACK, rd_ack_o=1 and rd_data_o SHALL be driven from the state of the current cycle, then the FSM SHALL move to RWAIT.
REQ-025 In RWAIT, the FSM SHALL return to RIDLE only after rd_req_i=0, so one request gives exactly one ack.
REQ-026 Ack latency SHALL be 2 cycles from rd_req_i rising.
REQ-027 Read word 0 SHALL be S[31:0].
REQ-028 Read word 1 SHALL be {armed, 21'b0, S[41:32]}.
REQ-029 Read word 2 SHALL be sticky[31:0].
REQ-030 Read word 3 SHALL be {counter[7:0], 14'b0, sticky[41:32]}.
REQ-031 A read coinciding with a clr_i update SHALL return the pre-clear value.
REQ-032 rd_data_o SHALL be 0 whenever rd_ack_o=0.

Reset
REQ-033 While wb_rstn_i=0 at a clock edge, all of the following SHALL clear: synchronizer flops, sticky, counter, settle counter, irq_o, rd_ack_o, rd_data_o; monitor FSM SHALL be SETTLE and read FSM RIDLE.
REQ-034 Reset asserted mid-read SHALL drop rd_ack_o the next cycle; no ack for that request is owed after reset release.
REQ-035 After reset release, mismatches present during the first SETTLE_CYCLES+2 cycles SHALL NOT set sticky.

Verification
REQ-036 Reset release, V=EXPECTED for 100 cycles, read word 3 -> rd_data_o=0, irq_o=0; word 1 bit 31=1.
REQ-037 After arming, spare_xi[0]=1 (V[27]) for 3 cycles -> sticky[27]=1, read word 3 = 0x0300_0000 | ... i.e. counter=3, word 1 bit 0 cleared.
REQ-038 Mismatch held 300 cycles -> counter reads 255.
REQ-039 spare_xz[5]=1 during SETTLE, cleared before arming -> word 2 reads 0, irq_o=0.
REQ-040 clr_i in the same cycle as a new mismatch on V[3] -> sticky[3]=1, counter=1.
REQ-041 rd_req_i held 10 cycles -> exactly one rd_ack_o pulse, at cycle 2; reset at cycle 1 of a request -> no ack.
